// File: rtl/time_pkg.sv
// time_pkg: shared mode encodings, default moduli and field widths for the clock datapath
package time_pkg;
  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_e;
  localparam int DEF_SEC_MAX  = 60;
  localparam int DEF_MIN_MAX  = 60;
  localparam int DEF_HOUR_MAX = 24;
  localparam int SEC_W  = 7;
  localparam int MIN_W  = 7;
  localparam int HOUR_W = 5;
  localparam int PRE_W  = 10;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchronizer plus rising-edge detect for one push-button
module btn_edge (
  input  logic new_clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic r_s1, r_s2, r_p;
  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end
  assign press = r_s2 & ~r_p;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: hh:mm:ss timekeeping with a two-button set mode for hours and minutes
module time_set_ctrl import time_pkg::*; #(
  parameter int TICKS_PER_SEC = 10,
  parameter int SEC_MAX       = DEF_SEC_MAX,
  parameter int MIN_MAX       = DEF_MIN_MAX,
  parameter int HOUR_MAX      = DEF_HOUR_MAX
) (
  input  logic              new_clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [1:0]        mode,
  output logic              sec_tick
);
  mode_e             r_mode, w_mode_nx;
  logic [PRE_W-1:0]  r_pre, w_pre_nx;
  logic [SEC_W-1:0]  r_sec, w_sec_nx;
  logic [MIN_W-1:0]  r_min, w_min_nx;
  logic [HOUR_W-1:0] r_hour, w_hour_nx;
  logic              r_tick, w_tick_nx;
  logic              w_mode_ev, w_inc_ev;
  logic              w_pre_top, w_sec_top, w_min_top, w_hour_top;

  btn_edge u_mode (.new_clk(new_clk), .rst(rst), .btn(btn_mode), .press(w_mode_ev));
  btn_edge u_inc  (.new_clk(new_clk), .rst(rst), .btn(btn_inc),  .press(w_inc_ev));

  // >= rather than == so a corrupted field still wraps on its next update
  assign w_pre_top  = r_pre  >= PRE_W'(TICKS_PER_SEC - 1);
  assign w_sec_top  = r_sec  >= SEC_W'(SEC_MAX - 1);
  assign w_min_top  = r_min  >= MIN_W'(MIN_MAX - 1);
  assign w_hour_top = r_hour >= HOUR_W'(HOUR_MAX - 1);

  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      r_mode <= MODE_RUN;
      r_pre  <= '0;
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_tick <= 1'b0;
    end else begin
      r_mode <= w_mode_nx;
      r_pre  <= w_pre_nx;
      r_sec  <= w_sec_nx;
      r_min  <= w_min_nx;
      r_hour <= w_hour_nx;
      r_tick <= w_tick_nx;
    end
  end

  always_comb begin
    w_mode_nx = r_mode;
    w_pre_nx  = r_pre;
    w_sec_nx  = r_sec;
    w_min_nx  = r_min;
    w_hour_nx = r_hour;
    w_tick_nx = 1'b0;
    case (r_mode)
      MODE_RUN: begin
        w_mode_nx = w_mode_ev ? MODE_SET_HOUR : MODE_RUN;
        w_pre_nx  = w_pre_top ? '0 : r_pre + 1'b1;
        if (w_pre_top) begin
          w_tick_nx = 1'b1;
          w_sec_nx  = w_sec_top ? '0 : r_sec + 1'b1;
          if (w_sec_top) w_min_nx = w_min_top ? '0 : r_min + 1'b1;
          if (w_sec_top && w_min_top) w_hour_nx = w_hour_top ? '0 : r_hour + 1'b1;
        end
      end
      MODE_SET_HOUR: begin
        w_pre_nx  = '0;
        w_mode_nx = w_mode_ev ? MODE_SET_MIN : MODE_SET_HOUR;
        if (!w_mode_ev && w_inc_ev) w_hour_nx = w_hour_top ? '0 : r_hour + 1'b1;
      end
      MODE_SET_MIN: begin
        w_pre_nx  = '0;
        w_mode_nx = w_mode_ev ? MODE_RUN : MODE_SET_MIN;
        if (w_mode_ev) w_sec_nx = '0;
        else if (w_inc_ev) w_min_nx = w_min_top ? '0 : r_min + 1'b1;
      end
      default: w_mode_nx = MODE_RUN;
    endcase
  end

  assign sec      = r_sec;
  assign min      = r_min;
  assign hour     = r_hour;
  assign mode     = r_mode;
  assign sec_tick = r_tick;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scenario tasks with a scoreboard of expected snapshots and tick times
module tb_time_set_ctrl;
  logic       new_clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [6:0] sec, min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       sec_tick;
  int tests_run = 0;
  int failed = 0;

  typedef struct {int hh; int mm; int ss; int md; int tk;} exp_t;
  exp_t sb[$];
  int   tick_q[$];

  time_set_ctrl #(.TICKS_PER_SEC(10)) dut (
    .new_clk(new_clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .mode(mode), .sec_tick(sec_tick)
  );

  always #5 new_clk = ~new_clk;

  task automatic do_reset();
    @(negedge new_clk);
    rst = 1'b0;
    @(negedge new_clk);
    rst = 1'b1;
  endtask

  // returns 1 ns after the edge on which the press takes effect
  task automatic press(input logic m, input logic i);
    repeat (2) @(negedge new_clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (3) @(posedge new_clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    sb.push_back('{0, 0, 0, 0, 0});
    repeat (3) @(posedge new_clk);
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, mode, sec_tick} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md), 1'(e.tk)}) begin
      failed++;
      $display("FAIL reset_state got %0d:%0d:%0d mode=%0d tick=%0d want 0:0:0 mode=0 tick=0", hour, min, sec, mode, sec_tick);
    end
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    sb.push_back('{0, 0, 0, 0, 0});
    repeat (6) @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if (mode !== 2'(e.md)) begin
      failed++;
      $display("FAIL reset_no_event got mode=%0d want %0d", mode, e.md);
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    int exp_k;
    do_reset();
    for (int j = 1; j <= 60; j++) tick_q.push_back(10 * j);
    sb.push_back('{0, 1, 0, 0, 1});
    for (int k = 1; k <= 605; k++) begin
      @(posedge new_clk);
      @(negedge new_clk);
      if (sec_tick === 1'b1) begin
        exp_k = tick_q.size() > 0 ? tick_q.pop_front() : -1;
        tests_run++;
        if (k !== exp_k) begin
          failed++;
          $display("FAIL tick_time got cycle %0d want %0d", k, exp_k);
        end
      end
      if (k == 600) begin
        e = sb.pop_front();
        tests_run++;
        if ({hour, min, sec, mode} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md)}) begin
          failed++;
          $display("FAIL free_run_600 got %0d:%0d:%0d want %0d:%0d:%0d", hour, min, sec, e.hh, e.mm, e.ss);
        end
      end
    end
    tests_run++;
    if (tick_q.size() != 0) begin
      failed++;
      $display("FAIL tick_count got %0d missing ticks want 0", tick_q.size());
      tick_q.delete();
    end
  endtask

  task automatic test_set_run();
    exp_t e;
    do_reset();
    press(1, 0);
    sb.push_back('{0, 0, 0, 1, 0});
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if (mode !== 2'(e.md)) begin
      failed++;
      $display("FAIL enter_set_hour got mode=%0d want %0d", mode, e.md);
    end
    repeat (23) press(0, 1);
    press(1, 0);
    repeat (59) press(0, 1);
    press(1, 0);
    sb.push_back('{23, 59, 0, 0, 0});
    sb.push_back('{23, 59, 59, 0, 1});
    sb.push_back('{23, 59, 59, 0, 0});
    sb.push_back('{0, 0, 0, 0, 1});
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, mode} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md)}) begin
      failed++;
      $display("FAIL set_done got %0d:%0d:%0d mode=%0d want 23:59:0 mode=0", hour, min, sec, mode);
    end
    repeat (590) @(posedge new_clk);
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, mode, sec_tick} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md), 1'(e.tk)}) begin
      failed++;
      $display("FAIL run_590 got %0d:%0d:%0d tick=%0d want 23:59:59 tick=1", hour, min, sec, sec_tick);
    end
    repeat (9) @(posedge new_clk);
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, sec_tick} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 1'(e.tk)}) begin
      failed++;
      $display("FAIL run_599 got %0d:%0d:%0d tick=%0d want 23:59:59 tick=0", hour, min, sec, sec_tick);
    end
    @(posedge new_clk);
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, sec_tick} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 1'(e.tk)}) begin
      failed++;
      $display("FAIL day_wrap got %0d:%0d:%0d tick=%0d want 0:0:0 tick=1", hour, min, sec, sec_tick);
    end
  endtask

  task automatic test_set_wrap();
    exp_t e;
    do_reset();
    press(1, 0);
    press(1, 0);
    repeat (59) press(0, 1);
    sb.push_back('{0, 59, 0, 2, 0});
    sb.push_back('{0, 0, 0, 2, 0});
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, mode} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md)}) begin
      failed++;
      $display("FAIL set_min_59 got %0d:%0d:%0d mode=%0d want 0:59:0 mode=2", hour, min, sec, mode);
    end
    press(0, 1);
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, mode} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md)}) begin
      failed++;
      $display("FAIL set_min_wrap got %0d:%0d:%0d mode=%0d want 0:0:0 mode=2", hour, min, sec, mode);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset();
    press(1, 0);
    repeat (5) press(0, 1);
    press(1, 1);
    sb.push_back('{5, 0, 0, 2, 0});
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, mode} !== {5'(e.hh), 7'(e.mm), 2'(e.md)}) begin
      failed++;
      $display("FAIL simultaneous got hour=%0d min=%0d mode=%0d want hour=5 min=0 mode=2", hour, min, mode);
    end
  endtask

  task automatic test_reset_mid_set();
    exp_t e;
    do_reset();
    press(1, 0);
    press(1, 0);
    repeat (30) press(0, 1);
    sb.push_back('{0, 30, 0, 2, 0});
    sb.push_back('{0, 0, 0, 0, 0});
    sb.push_back('{0, 0, 1, 0, 1});
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, mode} !== {5'(e.hh), 7'(e.mm), 2'(e.md)}) begin
      failed++;
      $display("FAIL pre_reset got min=%0d mode=%0d want min=30 mode=2", min, mode);
    end
    #2 rst = 1'b0;
    #1;
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, mode, sec_tick} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md), 1'(e.tk)}) begin
      failed++;
      $display("FAIL async_reset got %0d:%0d:%0d mode=%0d want 0:0:0 mode=0", hour, min, sec, mode);
    end
    @(negedge new_clk);
    rst = 1'b1;
    repeat (10) @(posedge new_clk);
    @(negedge new_clk);
    e = sb.pop_front();
    tests_run++;
    if ({hour, min, sec, mode, sec_tick} !== {5'(e.hh), 7'(e.mm), 7'(e.ss), 2'(e.md), 1'(e.tk)}) begin
      failed++;
      $display("FAIL resume_after_reset got %0d:%0d:%0d tick=%0d want 0:0:1 tick=1", hour, min, sec, sec_tick);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_set_run();
    test_set_wrap();
    test_simultaneous();
    test_reset_mid_set();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1);
  end
endmodule
